// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a wrapping register range through one read port and streams each word out
// Optional trailing checksum beat is enabled by defining DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   C_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0]   C_REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;
  logic              w_hs;
  logic              w_final;
  logic [ADDR_W:0]   w_count_eff;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_csum_beat;
`endif

  // Zero and anything beyond the file size both mean a full sweep.
  assign w_count_eff = ((count == '0) || (count > C_NUM_REGS)) ? C_NUM_REGS : count;
  assign w_hs        = (r_state == S_SEND) && out_ready;
  assign w_final     = (r_rem == C_REM_ONE);

  assign rd_addr  = r_ptr;
  assign out_data = r_data;
  assign out_addr = r_addr;
  assign out_last = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (w_hs) begin
`ifdef DUMP_CHECKSUM_EN
          if (r_csum_beat) begin
            w_next = S_FIN;
          end else if (w_final) begin
            w_next = S_SEND;
          end else begin
            w_next = S_LOAD;
          end
`else
          w_next = w_final ? S_FIN : S_LOAD;
`endif
        end
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_rem  <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_last <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_sum       <= '0;
      r_csum_beat <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr <= start_addr;
            r_rem <= w_count_eff;
`ifdef DUMP_CHECKSUM_EN
            r_sum       <= '0;
            r_csum_beat <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          r_data <= rd_data;
          r_addr <= r_ptr;
`ifdef DUMP_CHECKSUM_EN
          r_last <= 1'b0;
          r_sum  <= r_sum + rd_data;
`else
          r_last <= w_final;
`endif
        end
        S_SEND: begin
`ifdef DUMP_CHECKSUM_EN
          // Last register word accepted: reuse the SEND beat for the checksum.
          if (w_hs && !r_csum_beat) begin
            r_rem <= r_rem - C_REM_ONE;
            r_ptr <= r_ptr + C_PTR_ONE;
            if (w_final) begin
              r_data      <= r_sum;
              r_addr      <= '0;
              r_last      <= 1'b1;
              r_csum_beat <= 1'b1;
            end
          end
`else
          if (w_hs) begin
            r_rem <= r_rem - C_REM_ONE;
            r_ptr <= r_ptr + C_PTR_ONE;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  start_addr = '0;
  logic [4:0]  count = '0;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [16];
  logic [31:0] golden [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sa;
    logic [4:0] cnt;
    int         n;
    logic [3:0] last_a;
  } vec_t;
  vec_t vecs [6];

  regfile_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_regs();
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'(i) * 32'h11111111;
      golden[i] = 32'(i) * 32'h11111111;
    end
  endtask

  // race: 1 = write reg 3 during its LOAD cycle, 2 = write reg 3 after its LOAD
  task automatic run_dump(input logic [3:0] sa, input logic [4:0] cnt, input int n,
                          input logic [3:0] last_a, input int stall_k, input int stall_len,
                          input int race);
    int k = 0;
    int cyc = 0;
    int dones = 0;
    int stalled = 0;
    int total;
    bit fin = 1'b0;
    bit raced = 1'b0;
    logic [31:0] sum = '0;
    logic [31:0] exp_d;
    logic [3:0]  exp_a;
    logic        exp_l;
`ifdef DUMP_CHECKSUM_EN
    total = n + 1;
`else
    total = n;
`endif
    start_addr = sa;
    count      = cnt;
    start      = 1'b1;
    out_ready  = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      if (race == 1 && !raced && busy && !out_valid && !done && rd_addr == 4'd3) begin
        mem[3] = 32'hDEADBEEF;
        raced  = 1'b1;
      end
      if (out_valid) begin
        if (k < n) begin
          exp_a = sa + k[3:0];
          exp_d = golden[exp_a];
          exp_l = (k == total - 1);
        end else begin
          exp_a = 4'd0;
          exp_d = sum;
          exp_l = 1'b1;
        end
        if (k == stall_k && stalled < stall_len) begin
          out_ready = 1'b0;
          check("stall_data", out_data, exp_d);
          check("stall_addr", 32'(out_addr), 32'(exp_a));
          start_addr = 4'd7;
          count      = 5'd2;
          start      = (stalled == 1);
          stalled++;
        end else begin
          out_ready = 1'b1;
          start     = 1'b0;
          check("word_data", out_data, exp_d);
          check("word_addr", 32'(out_addr), 32'(exp_a));
          check("word_last", 32'(out_last), 32'(exp_l));
          if (k == n - 1) check("final_reg_addr", 32'(out_addr), 32'(last_a));
          if (race == 2 && !raced && out_addr == 4'd3) begin
            mem[3] = 32'hDEADBEEF;
            raced  = 1'b1;
          end
          sum = sum + exp_d;
          k++;
        end
      end
      if (done) begin
        dones++;
        fin = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check("dump_finished", 32'(fin), 32'd1);
    check("word_count", 32'(k), 32'(total));
    check("done_count", 32'(dones), 32'd1);
    start = 1'b0;
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    tick();
    check("no_queued_start", 32'(busy), 32'd0);
  endtask

  initial begin
    init_regs();
    vecs[0] = '{4'd0,  5'd0,  16, 4'd15};
    vecs[1] = '{4'd14, 5'd4,  4,  4'd1};
    vecs[2] = '{4'd5,  5'd1,  1,  4'd5};
    vecs[3] = '{4'd15, 5'd16, 16, 4'd14};
    vecs[4] = '{4'd3,  5'd20, 16, 4'd2};
    vecs[5] = '{4'd9,  5'd31, 16, 4'd8};

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Latency: start in N, LOAD in N+1, out_valid in N+2
    start_addr = 4'd6;
    count      = 5'd1;
    start      = 1'b1;
    out_ready  = 1'b0;
    tick();
    start = 1'b0;
    check("lat_load_busy", 32'(busy), 32'd1);
    check("lat_load_valid", 32'(out_valid), 32'd0);
    check("lat_rd_addr", 32'(rd_addr), 32'd6);
    tick();
    check("lat_send_valid", 32'(out_valid), 32'd1);
    check("lat_send_addr", 32'(out_addr), 32'd6);
    check("lat_send_data", out_data, 32'h66666666);
    out_ready = 1'b1;
    tick();
`ifndef DUMP_CHECKSUM_EN
    check("lat_fin_done", 32'(done), 32'd1);
    check("lat_fin_busy", 32'(busy), 32'd1);
    check("lat_fin_valid", 32'(out_valid), 32'd0);
`else
    for (int c = 0; c < 10 && !done; c++) tick();
    check("lat_fin_done", 32'(done), 32'd1);
`endif
    tick();
    check("lat_idle_done", 32'(done), 32'd0);
    check("lat_idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      run_dump(vecs[v].sa, vecs[v].cnt, vecs[v].n, vecs[v].last_a, -1, 0, 0);
    end

    run_dump(4'd0, 5'd0, 16, 4'd15, 2, 5, 0);

    golden[3] = 32'hDEADBEEF;
    run_dump(4'd2, 5'd3, 3, 4'd4, -1, 0, 1);
    init_regs();
    run_dump(4'd2, 5'd3, 3, 4'd4, -1, 0, 2);
    init_regs();

`ifdef DUMP_CHECKSUM_EN
    mem[0] = 32'd1;          golden[0] = 32'd1;
    mem[1] = 32'd2;          golden[1] = 32'd2;
    mem[2] = 32'hFFFFFFFF;   golden[2] = 32'hFFFFFFFF;
    run_dump(4'd0, 5'd3, 3, 4'd2, -1, 0, 0);
    init_regs();
`endif

    // Async reset in the middle of a SEND beat
    start_addr = 4'd0;
    count      = 5'd0;
    start      = 1'b1;
    out_ready  = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_addr", 32'(out_addr), 32'd0);
    check("midrst_rd_addr", 32'(rd_addr), 32'd0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("after_rst_busy", 32'(busy), 32'd0);
    check("after_rst_valid", 32'(out_valid), 32'd0);
    tick();
    check("after_rst_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
